// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_pkg;

    typedef enum logic [1:0] {
        FETCH    = 2'd0,
        BUFFERED = 2'd1,
        DRAIN    = 2'd2
    } fetch_state_e;

    localparam logic [31:0] NOP_INST = 32'h0000_0000;
    localparam int unsigned PC_INC   = 4;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: sync reset, flush-to-bubble, then write-enable.
module if_id_reg
    import fetch_pkg::*;
#(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned INST_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              we_i,
    input  logic              flush_i,
    input  logic [ADDR_W-1:0] pc_d_i,
    input  logic [INST_W-1:0] inst_d_i,
    input  logic              valid_d_i,
    output logic [ADDR_W-1:0] pc_q_o,
    output logic [INST_W-1:0] inst_q_o,
    output logic              valid_q_o
);

    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            pc_q_o    <= '0;
            inst_q_o  <= INST_W'(NOP_INST);
            valid_q_o <= 1'b0;
        end else if (we_i) begin
            pc_q_o    <= pc_d_i;
            inst_q_o  <= inst_d_i;
            valid_q_o <= valid_d_i;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage with IF/ID register. Optional bubble counter: FETCH_PERF_CNT_EN.
module fetch_stage
    import fetch_pkg::*;
#(
    parameter int unsigned       ADDR_W   = 32,
    parameter int unsigned       INST_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              PC_Write_i,
    input  logic              IF_ID_Write_i,
    input  logic              IF_Flush_i,
    input  logic [ADDR_W-1:0] Branch_Target_i,
    output logic              imem_req_o,
    output logic [ADDR_W-1:0] imem_addr_o,
    input  logic              imem_ready_i,
    input  logic [INST_W-1:0] imem_data_i,
    output logic [ADDR_W-1:0] IF_ID_PC_o,
    output logic [INST_W-1:0] IF_ID_Inst_o,
    output logic              IF_ID_Valid_o,
    output logic [31:0]       Bubble_Count_o
);

    fetch_state_e      state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] tgt_q, tgt_d;
    logic [INST_W-1:0] buf_q, buf_d;

    logic              adv;
    logic              flush;
    logic              ifid_we;
    logic              ifid_flush;
    logic [INST_W-1:0] ifid_inst_d;
    logic              ifid_valid_d;
    logic [ADDR_W-1:0] pc_inc;

    assign adv    = PC_Write_i && IF_ID_Write_i;
    // A stalled IF/ID means the branch in ID is re-resolved next cycle, so stall wins.
    assign flush  = IF_Flush_i && IF_ID_Write_i;
    assign pc_inc = pc_q + ADDR_W'(PC_INC);

    assign imem_req_o  = !rst_i && (state_q != BUFFERED);
    assign imem_addr_o = pc_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= FETCH;
            pc_q    <= RESET_PC;
            tgt_q   <= '0;
            buf_q   <= INST_W'(NOP_INST);
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            tgt_q   <= tgt_d;
            buf_q   <= buf_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        tgt_d        = tgt_q;
        buf_d        = buf_q;
        ifid_we      = 1'b0;
        ifid_flush   = 1'b0;
        ifid_inst_d  = INST_W'(NOP_INST);
        ifid_valid_d = 1'b0;

        case (state_q)
            FETCH: begin
                if (flush) begin
                    ifid_flush = 1'b1;
                    buf_d      = INST_W'(NOP_INST);
                    if (imem_ready_i) begin
                        pc_d = Branch_Target_i;
                    end else begin
                        // Request is outstanding: the address must stay put until it completes.
                        tgt_d   = Branch_Target_i;
                        state_d = DRAIN;
                    end
                end else if (imem_ready_i) begin
                    if (adv) begin
                        ifid_we      = 1'b1;
                        ifid_inst_d  = imem_data_i;
                        ifid_valid_d = 1'b1;
                        pc_d         = pc_inc;
                    end else begin
                        buf_d   = imem_data_i;
                        state_d = BUFFERED;
                    end
                end else if (adv) begin
                    ifid_we = 1'b1;
                end
            end

            BUFFERED: begin
                if (flush) begin
                    ifid_flush = 1'b1;
                    buf_d      = INST_W'(NOP_INST);
                    pc_d       = Branch_Target_i;
                    state_d    = FETCH;
                end else if (adv) begin
                    ifid_we      = 1'b1;
                    ifid_inst_d  = buf_q;
                    ifid_valid_d = 1'b1;
                    pc_d         = pc_inc;
                    buf_d        = INST_W'(NOP_INST);
                    state_d      = FETCH;
                end
            end

            DRAIN: begin
                if (flush) begin
                    ifid_flush = 1'b1;
                    if (imem_ready_i) begin
                        pc_d    = Branch_Target_i;
                        state_d = FETCH;
                    end else begin
                        tgt_d = Branch_Target_i;
                    end
                end else begin
                    ifid_we = adv;
                    if (imem_ready_i) begin
                        pc_d    = tgt_q;
                        state_d = FETCH;
                    end
                end
            end

            default: state_d = FETCH;
        endcase
    end

    if_id_reg #(
        .ADDR_W (ADDR_W),
        .INST_W (INST_W)
    ) u_if_id_reg (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .we_i      (ifid_we),
        .flush_i   (ifid_flush),
        .pc_d_i    (pc_q),
        .inst_d_i  (ifid_inst_d),
        .valid_d_i (ifid_valid_d),
        .pc_q_o    (IF_ID_PC_o),
        .inst_q_o  (IF_ID_Inst_o),
        .valid_q_o (IF_ID_Valid_o)
    );

`ifdef FETCH_PERF_CNT_EN
    logic        bubble_evt;
    logic [31:0] bubble_cnt_q;

    // Bubbles from a pending fetch; flush bubbles are not counted.
    assign bubble_evt = adv && !flush &&
                        ((state_q == FETCH && !imem_ready_i) || state_q == DRAIN);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            bubble_cnt_q <= '0;
        end else if (bubble_evt) begin
            bubble_cnt_q <= bubble_cnt_q + 32'd1;
        end
    end

    assign Bubble_Count_o = bubble_cnt_q;
`else
    assign Bubble_Count_o = '0;
`endif

endmodule
